schedule_reader: RTL and testbench

Read-side counterpart of the RMI schedule writer. RMI writes each new schedule into one of two ping-pong BRAMs and flips `selMem`. This block reads the bank that `selMem` marks as current and streams its entries to the schedule consumer over a valid/ready handshake. It sits between the BRAM read ports and the consumer. The bank is latched per frame, so the reader is never affected by a bank switch in the middle of a frame.

---
 rtl/schedule_reader.sv | 124 ++++++++++++
 tb/tb_schedule_reader.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/schedule_reader.sv
// Streams one frame of schedule entries from the ping-pong BRAM bank that was
// current when the frame started, presenting each entry over a valid/ready handshake.
module schedule_reader #(
  parameter logic [31:0] BASE_ADDR = 32'd0,
  parameter int unsigned LEN_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             selMem,
  input  logic             start,
  input  logic [LEN_W-1:0] schedLen,
  output logic             rdEn1,
  output logic [31:0]      rdAdd1,
  input  logic [31:0]      rdData1,
  output logic             rdEn2,
  output logic [31:0]      rdAdd2,
  input  logic [31:0]      rdData2,
  output logic             schedValid,
  output logic [31:0]      schedData,
  output logic [LEN_W-1:0] schedIdx,
  input  logic             schedReady,
  output logic             schedDone,
  output logic             busy,
  output logic             bankUsed
);

  typedef enum logic [2:0] {IDLE, ISSUE, CAPTURE, PRESENT, DONE} state_t;

  state_t           state;
  logic [LEN_W-1:0] idx;
  logic [LEN_W-1:0] len;
  logic [LEN_W-1:0] issueIdx;
  logic [31:0]      issueAddr;
  logic             issueBank;
  logic [31:0]      capData;

  // Read enable/address are registered, so they are computed for the entry
  // about to be issued: index 0 from IDLE, idx+1 after a handshake in PRESENT.
  always_comb begin
    issueIdx  = (state == PRESENT) ? idx + LEN_W'(1) : '0;
    issueAddr = BASE_ADDR + 32'(issueIdx);
    issueBank = (state == IDLE) ? selMem : bankUsed;
    capData   = bankUsed ? rdData2 : rdData1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      idx        <= '0;
      len        <= '0;
      rdEn1      <= 1'b0;
      rdAdd1     <= '0;
      rdEn2      <= 1'b0;
      rdAdd2     <= '0;
      schedValid <= 1'b0;
      schedData  <= '0;
      schedIdx   <= '0;
      schedDone  <= 1'b0;
      busy       <= 1'b0;
      bankUsed   <= 1'b0;
    end else begin
      rdEn1     <= 1'b0;
      rdAdd1    <= '0;
      rdEn2     <= 1'b0;
      rdAdd2    <= '0;
      schedDone <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            bankUsed <= selMem;
            len      <= schedLen;
            idx      <= '0;
            busy     <= 1'b1;
            if (schedLen == '0) begin
              state     <= DONE;
              schedDone <= 1'b1;
            end else begin
              state <= ISSUE;
              if (issueBank) begin
                rdEn2  <= 1'b1;
                rdAdd2 <= issueAddr;
              end else begin
                rdEn1  <= 1'b1;
                rdAdd1 <= issueAddr;
              end
            end
          end
        end
        ISSUE: state <= CAPTURE;
        CAPTURE: begin
          schedData  <= capData;
          schedIdx   <= idx;
          schedValid <= 1'b1;
          state      <= PRESENT;
        end
        PRESENT: begin
          if (schedReady) begin
            schedValid <= 1'b0;
            if (idx == len - LEN_W'(1)) begin
              state     <= DONE;
              schedDone <= 1'b1;
            end else begin
              idx   <= issueIdx;
              state <= ISSUE;
              if (issueBank) begin
                rdEn2  <= 1'b1;
                rdAdd2 <= issueAddr;
              end else begin
                rdEn1  <= 1'b1;
                rdAdd1 <= issueAddr;
              end
            end
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_schedule_reader.sv
// Directed bench for schedule_reader with two registered-read BRAM models.
module tb_schedule_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        selMem;
  logic        start;
  logic [7:0]  schedLen;
  logic        rdEn1, rdEn2;
  logic [31:0] rdAdd1, rdAdd2;
  logic [31:0] rdData1, rdData2;
  logic        schedValid;
  logic [31:0] schedData;
  logic [7:0]  schedIdx;
  logic        schedReady;
  logic        schedDone;
  logic        busy;
  logic        bankUsed;

  logic [31:0] mem1 [256];
  logic [31:0] mem2 [256];

  int assertions = 0;
  int failures   = 0;
  int rd1Cnt = 0, rd2Cnt = 0, doneCnt = 0;

  always #5 clk = ~clk;

  schedule_reader #(.BASE_ADDR(32'd0), .LEN_W(8)) dut (
    .clk(clk), .rst(rst), .selMem(selMem), .start(start), .schedLen(schedLen),
    .rdEn1(rdEn1), .rdAdd1(rdAdd1), .rdData1(rdData1),
    .rdEn2(rdEn2), .rdAdd2(rdAdd2), .rdData2(rdData2),
    .schedValid(schedValid), .schedData(schedData), .schedIdx(schedIdx),
    .schedReady(schedReady), .schedDone(schedDone), .busy(busy), .bankUsed(bankUsed)
  );

  always @(posedge clk) begin
    if (rdEn1) rdData1 <= mem1[rdAdd1[7:0]];
    if (rdEn2) rdData2 <= mem2[rdAdd2[7:0]];
  end

  always @(negedge clk) begin
    if (rdEn1) rd1Cnt++;
    if (rdEn2) rd2Cnt++;
    if (schedDone) doneCnt++;
  end

  task automatic pulseStart(input logic bank, input logic [7:0] n);
    selMem = bank; schedLen = n; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b0; start = 1'b0; selMem = 1'b0; schedLen = '0; schedReady = 1'b1;
    repeat (2) @(negedge clk);
    assertions++;
    if ({rdEn1, rdEn2, rdAdd1, rdAdd2, schedValid, schedData, schedIdx, schedDone, busy, bankUsed} !== 110'd0) begin
      failures++;
      $display("FAIL reset_outputs got=%h exp=0",
               {rdEn1, rdEn2, rdAdd1, rdAdd2, schedValid, schedData, schedIdx, schedDone, busy, bankUsed});
    end
    rst = 1'b1;
    @(negedge clk);
    assertions++;
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_idle_busy got=%b exp=0", busy); end
  endtask

  task automatic test_basic;
    int r1, r2;
    r1 = rd1Cnt; r2 = rd2Cnt;
    schedReady = 1'b1;
    pulseStart(1'b0, 8'd4);
    for (int k = 1; k <= 14; k++) begin
      if (k <= 12) begin
        int e, ph;
        e = (k - 1) / 3; ph = (k - 1) % 3;
        if (ph == 0) begin
          assertions++;
          if ({rdEn1, rdEn2, rdAdd1} !== {1'b1, 1'b0, 32'(e)}) begin
            failures++; $display("FAIL basic_issue k=%0d got=%b%b %h exp=10 %h", k, rdEn1, rdEn2, rdAdd1, 32'(e));
          end
        end else if (ph == 2) begin
          assertions++;
          if ({schedValid, schedData, schedIdx} !== {1'b1, 32'(5 + e), 8'(e)}) begin
            failures++; $display("FAIL basic_entry k=%0d got=%b %h %0d exp=1 %h %0d", k, schedValid, schedData, schedIdx, 32'(5 + e), e);
          end
        end
      end
      assertions++;
      if (schedDone !== (k == 13)) begin
        failures++; $display("FAIL basic_done k=%0d got=%b exp=%b", k, schedDone, (k == 13));
      end
      @(negedge clk);
    end
    assertions++;
    if ((rd1Cnt - r1) != 4 || (rd2Cnt - r2) != 0) begin
      failures++; $display("FAIL basic_reads got=%0d/%0d exp=4/0", rd1Cnt - r1, rd2Cnt - r2);
    end
  endtask

  task automatic test_bank2;
    int r1, r2;
    r1 = rd1Cnt; r2 = rd2Cnt;
    pulseStart(1'b1, 8'd1);
    assertions++;
    if ({rdEn2, rdAdd2, rdEn1} !== {1'b1, 32'd0, 1'b0}) begin
      failures++; $display("FAIL bank2_issue got=%b %h %b exp=1 0 0", rdEn2, rdAdd2, rdEn1);
    end
    repeat (2) @(negedge clk);
    assertions++;
    if ({schedValid, schedData, bankUsed} !== {1'b1, 32'hDEADBEEF, 1'b1}) begin
      failures++; $display("FAIL bank2_entry got=%b %h %b exp=1 deadbeef 1", schedValid, schedData, bankUsed);
    end
    @(negedge clk);
    assertions++;
    if ({schedDone, bankUsed} !== 2'b11) begin
      failures++; $display("FAIL bank2_done got=%b%b exp=11", schedDone, bankUsed);
    end
    @(negedge clk);
    assertions++;
    if ((rd1Cnt - r1) != 0 || (rd2Cnt - r2) != 1) begin
      failures++; $display("FAIL bank2_reads got=%0d/%0d exp=0/1", rd1Cnt - r1, rd2Cnt - r2);
    end
  endtask

  task automatic test_mid_switch;
    int r1, r2;
    r1 = rd1Cnt; r2 = rd2Cnt;
    pulseStart(1'b0, 8'd4);
    for (int k = 1; k <= 13; k++) begin
      if (k == 4) selMem = 1'b1;
      if (k <= 12 && (k % 3) == 0) begin
        assertions++;
        if ({schedData, schedIdx, bankUsed} !== {32'(4 + k / 3), 8'(k / 3 - 1), 1'b0}) begin
          failures++; $display("FAIL switch_entry k=%0d got=%h %0d %b exp=%h %0d 0", k, schedData, schedIdx, bankUsed, 32'(4 + k / 3), k / 3 - 1);
        end
      end
      if (k == 13) begin
        assertions++;
        if (schedDone !== 1'b1) begin failures++; $display("FAIL switch_done got=%b exp=1", schedDone); end
      end
      @(negedge clk);
    end
    assertions++;
    if ((rd1Cnt - r1) != 4 || (rd2Cnt - r2) != 0) begin
      failures++; $display("FAIL switch_reads got=%0d/%0d exp=4/0", rd1Cnt - r1, rd2Cnt - r2);
    end
    pulseStart(1'b1, 8'd1);
    repeat (2) @(negedge clk);
    assertions++;
    if ({schedData, bankUsed} !== {32'hDEADBEEF, 1'b1}) begin
      failures++; $display("FAIL switch_next got=%h %b exp=deadbeef 1", schedData, bankUsed);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_backpressure;
    int r1, r2, d;
    d = doneCnt;
    schedReady = 1'b1;
    pulseStart(1'b0, 8'd4);
    for (int k = 1; k <= 23; k++) begin
      if (k == 8) schedReady = 1'b0;
      if (k == 9) begin r1 = rd1Cnt; r2 = rd2Cnt; end
      if (k >= 9 && k <= 18) begin
        assertions++;
        if ({schedValid, schedData, schedIdx} !== {1'b1, 32'd7, 8'd2}) begin
          failures++; $display("FAIL stall_hold k=%0d got=%b %h %0d exp=1 7 2", k, schedValid, schedData, schedIdx);
        end
      end
      if (k == 18) begin
        assertions++;
        if (rd1Cnt != r1 || rd2Cnt != r2) begin
          failures++; $display("FAIL stall_reads got=%0d exp=0", (rd1Cnt - r1) + (rd2Cnt - r2));
        end
        schedReady = 1'b1;
      end
      if (k == 19) begin
        assertions++;
        if ({rdEn1, rdAdd1} !== {1'b1, 32'd3}) begin
          failures++; $display("FAIL stall_resume got=%b %h exp=1 3", rdEn1, rdAdd1);
        end
      end
      if (k == 22) begin
        assertions++;
        if (schedDone !== 1'b1) begin failures++; $display("FAIL stall_done got=%b exp=1", schedDone); end
      end
      @(negedge clk);
    end
    assertions++;
    if (doneCnt - d != 1) begin failures++; $display("FAIL stall_donecnt got=%0d exp=1", doneCnt - d); end
  endtask

  task automatic test_zero_and_ignored;
    int r1, r2;
    r1 = rd1Cnt; r2 = rd2Cnt;
    pulseStart(1'b0, 8'd0);
    assertions++;
    if ({schedDone, rdEn1, rdEn2} !== 3'b100) begin
      failures++; $display("FAIL zero_done got=%b%b%b exp=100", schedDone, rdEn1, rdEn2);
    end
    @(negedge clk);
    assertions++;
    if ({busy, rd1Cnt - r1, rd2Cnt - r2} !== {1'b0, 32'd0, 32'd0}) begin
      failures++; $display("FAIL zero_idle got=busy %b reads %0d/%0d exp=0 0/0", busy, rd1Cnt - r1, rd2Cnt - r2);
    end
    r1 = rd1Cnt; r2 = rd2Cnt;
    pulseStart(1'b0, 8'd2);
    for (int k = 1; k <= 8; k++) begin
      if (k == 2 || k == 7) begin selMem = 1'b1; schedLen = 8'd5; start = 1'b1; end
      if (k == 3 || k == 8) start = 1'b0;
      if (k == 6) begin
        assertions++;
        if ({schedData, schedIdx} !== {32'd6, 8'd1}) begin
          failures++; $display("FAIL ignored_entry got=%h %0d exp=6 1", schedData, schedIdx);
        end
      end
      if (k == 7) begin
        assertions++;
        if ({schedDone, bankUsed} !== 2'b10) begin
          failures++; $display("FAIL ignored_done got=%b%b exp=10", schedDone, bankUsed);
        end
      end
      if (k == 8) begin
        assertions++;
        if ({busy, rdEn1, rdEn2} !== 3'b000) begin
          failures++; $display("FAIL done_start_ignored got=%b%b%b exp=000", busy, rdEn1, rdEn2);
        end
      end
      @(negedge clk);
    end
    assertions++;
    if ((rd1Cnt - r1) != 2 || (rd2Cnt - r2) != 0) begin
      failures++; $display("FAIL ignored_reads got=%0d/%0d exp=2/0", rd1Cnt - r1, rd2Cnt - r2);
    end
  endtask

  task automatic test_reset_mid;
    int d;
    d = doneCnt;
    schedReady = 1'b0;
    pulseStart(1'b0, 8'd4);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    assertions++;
    if ({rdEn1, rdEn2, rdAdd1, rdAdd2, schedValid, schedData, schedIdx, schedDone, busy, bankUsed} !== 110'd0) begin
      failures++;
      $display("FAIL midreset_outputs got=%h exp=0",
               {rdEn1, rdEn2, rdAdd1, rdAdd2, schedValid, schedData, schedIdx, schedDone, busy, bankUsed});
    end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    schedReady = 1'b1;
    repeat (2) @(negedge clk);
    assertions++;
    if (doneCnt != d) begin failures++; $display("FAIL midreset_nodone got=%0d exp=0", doneCnt - d); end
    pulseStart(1'b0, 8'd2);
    for (int k = 1; k <= 8; k++) begin
      if (k == 3 || k == 6) begin
        assertions++;
        if ({schedValid, schedData, schedIdx} !== {1'b1, 32'(4 + k / 3), 8'(k / 3 - 1)}) begin
          failures++; $display("FAIL midreset_entry k=%0d got=%b %h %0d exp=1 %h %0d", k, schedValid, schedData, schedIdx, 32'(4 + k / 3), k / 3 - 1);
        end
      end
      if (k == 7) begin
        assertions++;
        if (schedDone !== 1'b1) begin failures++; $display("FAIL midreset_done got=%b exp=1", schedDone); end
      end
      @(negedge clk);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem1[i] = 32'h1000_0000 + 32'(i);
      mem2[i] = 32'h2000_0000 + 32'(i);
    end
    mem1[0] = 32'd5; mem1[1] = 32'd6; mem1[2] = 32'd7; mem1[3] = 32'd8;
    mem2[0] = 32'hDEADBEEF;
    rdData1 = '0; rdData2 = '0;
    rst = 1'b0; start = 1'b0; selMem = 1'b0; schedLen = '0; schedReady = 1'b1;
    @(negedge clk);
    test_reset;
    test_basic;
    test_bank2;
    test_mid_switch;
    test_backpressure;
    test_zero_and_ignored;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
